// File: rtl/conv_scan_ctrl_pkg.sv
// Shared types, default geometry and width helpers for the convolution scan controller.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

    localparam int DEF_TILE_ROWS = 10;
    localparam int DEF_TILE_COLS = 8;
    localparam int DEF_ROW_STEP  = 8;
    localparam int DEF_COL_STEP  = 8;
    localparam int DEF_N_TR      = 2;
    localparam int DEF_N_TC      = 2;

    // Width of an index ranging over 0..n-1; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int tile_w(input int n_tr, input int n_tc);
        return idx_w(n_tr * n_tc);
    endfunction

endpackage

// File: rtl/conv_scan_ctrl_if.sv
// Coordinate stream from the scan controller to the convolution datapath.
interface conv_scan_ctrl_if #(
    parameter int COORD_W = 7,
    parameter int TILE_W  = 2
);
    // Handshake: a beat transfers on any rising edge where out_valid && out_ready.
    // The source holds every payload field stable while out_valid && !out_ready;
    // out_valid never depends combinationally on out_ready.
    logic               out_valid;
    logic               out_ready;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic [TILE_W-1:0]  tile;
    logic               first_in_tile;
    logic               last_in_tile;
    logic               last_frame;

    modport master (
        output out_valid, row, col, tile, first_in_tile, last_in_tile, last_frame,
        input  out_ready
    );

    modport slave (
        input  out_valid, row, col, tile, first_in_tile, last_in_tile, last_frame,
        output out_ready
    );

endinterface

// File: rtl/conv_scan_ctrl_coord_gen.sv
// Tile/window coordinate generator: local r/c counters, tile counters and
// incrementally accumulated tile origins, with registered coordinates and flags.
module scan_coord_gen
    import conv_pkg::*;
#(
    parameter int COORD_W   = 7,
    parameter int TILE_ROWS = DEF_TILE_ROWS,
    parameter int TILE_COLS = DEF_TILE_COLS,
    parameter int ROW_STEP  = DEF_ROW_STEP,
    parameter int COL_STEP  = DEF_COL_STEP,
    parameter int N_TR      = DEF_N_TR,
    parameter int N_TC      = DEF_N_TC,
    localparam int TW       = tile_w(N_TR, N_TC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic               advance,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic [TW-1:0]      tile,
    output logic               first_in_tile,
    output logic               last_in_tile,
    output logic               last_frame
);

    localparam int RW  = idx_w(TILE_ROWS);
    localparam int CW  = idx_w(TILE_COLS);
    localparam int TRW = idx_w(N_TR);
    localparam int TCW = idx_w(N_TC);

    logic [RW-1:0]      r, r_n;
    logic [CW-1:0]      c, c_n;
    logic [TRW-1:0]     tr, tr_n;
    logic [TCW-1:0]     tc, tc_n;
    logic [COORD_W-1:0] row_org, row_org_n, col_org, col_org_n;
    logic [COORD_W-1:0] row_n, col_n;
    logic [TW-1:0]      tile_n;
    logic               first_n, last_tile_n, last_frame_n;

    always_comb begin
        r_n         = r;
        c_n         = c;
        tr_n        = tr;
        tc_n        = tc;
        row_org_n   = row_org;
        col_org_n   = col_org;
        row_n       = row;
        col_n       = col;
        tile_n      = tile;

        if (clear || load) begin
            r_n       = '0;
            c_n       = '0;
            tr_n      = '0;
            tc_n      = '0;
            row_org_n = '0;
            col_org_n = '0;
            row_n     = '0;
            col_n     = '0;
            tile_n    = '0;
        end else if (advance) begin
            if (r != RW'(TILE_ROWS - 1)) begin
                r_n   = r + RW'(1);
                row_n = row + COORD_W'(1);
            end else begin
                r_n   = '0;
                row_n = row_org;
                if (c != CW'(TILE_COLS - 1)) begin
                    c_n   = c + CW'(1);
                    col_n = col + COORD_W'(1);
                end else begin
                    c_n   = '0;
                    col_n = col_org;
                    // Tile index tc*N_TR+tr advances by one on every tile change.
                    if (tr != TRW'(N_TR - 1)) begin
                        tr_n      = tr + TRW'(1);
                        row_org_n = row_org + COORD_W'(ROW_STEP);
                        row_n     = row_org + COORD_W'(ROW_STEP);
                        tile_n    = tile + TW'(1);
                    end else begin
                        tr_n      = '0;
                        row_org_n = '0;
                        row_n     = '0;
                        if (tc != TCW'(N_TC - 1)) begin
                            tc_n      = tc + TCW'(1);
                            col_org_n = col_org + COORD_W'(COL_STEP);
                            col_n     = col_org + COORD_W'(COL_STEP);
                            tile_n    = tile + TW'(1);
                        end else begin
                            tc_n      = '0;
                            col_org_n = '0;
                            col_n     = '0;
                            tile_n    = '0;
                        end
                    end
                end
            end
        end

        first_n      = first_in_tile;
        last_tile_n  = last_in_tile;
        last_frame_n = last_frame;
        if (clear) begin
            first_n      = 1'b0;
            last_tile_n  = 1'b0;
            last_frame_n = 1'b0;
        end else if (load || advance) begin
            first_n      = (r_n == '0) && (c_n == '0);
            last_tile_n  = (r_n == RW'(TILE_ROWS - 1)) && (c_n == CW'(TILE_COLS - 1));
            last_frame_n = last_tile_n && (tr_n == TRW'(N_TR - 1)) && (tc_n == TCW'(N_TC - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r             <= '0;
            c             <= '0;
            tr            <= '0;
            tc            <= '0;
            row_org       <= '0;
            col_org       <= '0;
            row           <= '0;
            col           <= '0;
            tile          <= '0;
            first_in_tile <= 1'b0;
            last_in_tile  <= 1'b0;
            last_frame    <= 1'b0;
        end else begin
            r             <= r_n;
            c             <= c_n;
            tr            <= tr_n;
            tc            <= tc_n;
            row_org       <= row_org_n;
            col_org       <= col_org_n;
            row           <= row_n;
            col           <= col_n;
            tile          <= tile_n;
            first_in_tile <= first_n;
            last_in_tile  <= last_tile_n;
            last_frame    <= last_frame_n;
        end
    end

endmodule

// File: rtl/conv_scan_ctrl.sv
// Frame scan controller: sequences coordinate beats over a valid/ready stream,
// waits out the MAC pipeline latency and pulses done; abortable at any time.
module conv_scan_ctrl
    import conv_pkg::*;
#(
    parameter int COORD_W   = 7,
    parameter int TILE_ROWS = DEF_TILE_ROWS,
    parameter int TILE_COLS = DEF_TILE_COLS,
    parameter int ROW_STEP  = DEF_ROW_STEP,
    parameter int COL_STEP  = DEF_COL_STEP,
    parameter int N_TR      = DEF_N_TR,
    parameter int N_TC      = DEF_N_TC,
    parameter int PIPE_LAT  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output scan_state_t    state,
    conv_scan_ctrl_if.master bus
);

    localparam int DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

    if ((N_TR - 1) * ROW_STEP + TILE_ROWS - 1 >= 2 ** COORD_W) begin : g_row_range
        $error("conv_scan_ctrl: COORD_W too narrow for the row range");
    end
    if ((N_TC - 1) * COL_STEP + TILE_COLS - 1 >= 2 ** COORD_W) begin : g_col_range
        $error("conv_scan_ctrl: COORD_W too narrow for the column range");
    end

    scan_state_t   state_q, state_n;
    logic [DW-1:0] cnt, cnt_n;
    logic          done_n;
    logic          fire;
    logic          clear, load, advance;

    assign fire  = bus.out_valid && bus.out_ready;
    assign state = state_q;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt;
        done_n  = 1'b0;
        clear   = 1'b0;
        load    = 1'b0;
        advance = 1'b0;

        if (abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            clear   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_n = RUN;
                        load    = 1'b1;
                    end
                end
                RUN: begin
                    if (fire) begin
                        if (bus.last_frame) begin
                            // Coordinates return to zero once the frame is issued.
                            clear = 1'b1;
                            if (PIPE_LAT > 0) begin
                                state_n = DRAIN;
                                cnt_n   = DW'(PIPE_LAT);
                            end else begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt <= DW'(1)) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        cnt_n = cnt - DW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_n;
            cnt           <= cnt_n;
            bus.out_valid <= (state_n == RUN);
            busy          <= (state_n != IDLE);
            done          <= done_n;
        end
    end

    scan_coord_gen #(
        .COORD_W   (COORD_W),
        .TILE_ROWS (TILE_ROWS),
        .TILE_COLS (TILE_COLS),
        .ROW_STEP  (ROW_STEP),
        .COL_STEP  (COL_STEP),
        .N_TR      (N_TR),
        .N_TC      (N_TC)
    ) u_coord (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .load          (load),
        .advance       (advance),
        .row           (bus.row),
        .col           (bus.col),
        .tile          (bus.tile),
        .first_in_tile (bus.first_in_tile),
        .last_in_tile  (bus.last_in_tile),
        .last_frame    (bus.last_frame)
    );

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Directed bench for conv_scan_ctrl: default geometry with PIPE_LAT=4 and a PIPE_LAT=0 instance.
module tb_conv_scan_ctrl;
    import conv_pkg::*;

    localparam int BEATS = 320;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic        start0 = 1'b0, abort0 = 1'b0;
    logic        busy, done, busy0, done0;
    scan_state_t state, state0;

    int n_pass = 0;
    int n_total = 0;
    int bd_viol = 0;
    int bd_viol0 = 0;

    conv_scan_ctrl_if #(.COORD_W(7), .TILE_W(2)) bus ();
    conv_scan_ctrl_if #(.COORD_W(7), .TILE_W(2)) bus0 ();

    conv_scan_ctrl #(.PIPE_LAT(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .state(state), .bus(bus)
    );

    conv_scan_ctrl #(.PIPE_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .busy(busy0), .done(done0), .state(state0), .bus(bus0)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy && done) bd_viol++;
        if (busy0 && done0) bd_viol0++;
    end

    // Expected {row, col, tile, first_in_tile, last_in_tile, last_frame} of beat k.
    function automatic logic [18:0] exp_beat(input int k);
        int ti, w, r, c, tr, tc;
        logic [6:0] er, ec;
        logic [1:0] et;
        ti = k / 80;
        w  = k % 80;
        c  = w / 10;
        r  = w % 10;
        tr = ti % 2;
        tc = ti / 2;
        er = 7'(tr * 8 + r);
        ec = 7'(tc * 8 + c);
        et = 2'(ti);
        return {er, ec, et, (r == 0 && c == 0), (r == 9 && c == 7), (r == 9 && c == 7 && ti == 3)};
    endfunction

    function automatic logic [18:0] obs_beat();
        return {bus.row, bus.col, bus.tile, bus.first_in_tile, bus.last_in_tile, bus.last_frame};
    endfunction

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents beats until stop_at beats have been accepted; every cycle the
    // payload must match the beat currently owed, which also proves stall stability.
    task automatic run_beats(input int ready_pct, input bit poke, input int stop_at,
                             output int n_beats, output int n_cycles);
        int k = 0;
        int cyc = 0;
        while (k < stop_at && cyc < 4000) begin
            n_total++;
            if (bus.out_valid !== 1'b1 || obs_beat() !== exp_beat(k))
                $display("FAIL beat %0d: got valid=%b payload=%h, want valid=1 payload=%h",
                         k, bus.out_valid, obs_beat(), exp_beat(k));
            else n_pass++;
            bus.out_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
            start = poke && (k == 5 || k == 200);
            if (bus.out_ready) k++;
            cyc++;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        start = 1'b0;
        n_total++;
        if (k != stop_at) $display("FAIL beat_timeout: got %0d beats, want %0d", k, stop_at);
        else n_pass++;
        n_beats = k;
        n_cycles = cyc;
    endtask

    // Called at the first falling edge after the final accept.
    task automatic check_drain(input bit poke, input bit do_rst);
        int n_done = 0;
        int done_at = -1;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                n_total++;
                if (bus.out_valid !== 1'b0 || busy !== 1'b1)
                    $display("FAIL drain_entry: got valid=%b busy=%b, want valid=0 busy=1", bus.out_valid, busy);
                else n_pass++;
            end
            if (done === 1'b1) begin
                n_done++;
                done_at = i;
            end
            if (do_rst && i == 3) begin
                n_total++;
                if ({bus.out_valid, busy, done, obs_beat()} !== 22'd0 || state !== IDLE)
                    $display("FAIL rst_drain_outputs: got valid=%b busy=%b done=%b payload=%h state=%0d, want all 0",
                             bus.out_valid, busy, done, obs_beat(), state);
                else n_pass++;
            end
            start = poke && (i == 1);
            rst = do_rst && (i == 2);
            @(negedge clk);
        end
        start = 1'b0;
        rst = 1'b0;
        n_total++;
        if (do_rst) begin
            if (n_done != 0) $display("FAIL rst_no_done: got %0d done pulses, want 0", n_done);
            else n_pass++;
        end else begin
            if (n_done != 1 || done_at != 4)
                $display("FAIL done_timing: got %0d pulses last at edge %0d, want 1 at edge 4", n_done, done_at);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({bus.out_valid, busy, done, obs_beat()} !== 22'd0)
            $display("FAIL reset_outputs: got valid=%b busy=%b done=%b payload=%h, want all 0",
                     bus.out_valid, busy, done, obs_beat());
        else n_pass++;
        n_total++;
        if (state !== IDLE || state0 !== IDLE || bus0.out_valid !== 1'b0)
            $display("FAIL reset_state: got state=%0d state0=%0d valid0=%b, want 0 0 0", state, state0, bus0.out_valid);
        else n_pass++;
    endtask

    task automatic test_start_abort();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || state !== IDLE)
            $display("FAIL start_abort: got valid=%b busy=%b state=%0d, want 0 0 IDLE", bus.out_valid, busy, state);
        else n_pass++;
    endtask

    task automatic test_basic();
        int nb, nc;
        start_frame();
        n_total++;
        if (busy !== 1'b1 || state !== RUN)
            $display("FAIL start_busy: got busy=%b state=%0d, want busy=1 RUN", busy, state);
        else n_pass++;
        run_beats(100, 1'b0, BEATS, nb, nc);
        n_total++;
        if (nc != BEATS) $display("FAIL basic_cycles: got %0d cycles, want %0d", nc, BEATS);
        else n_pass++;
        check_drain(1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        int nb, nc;
        start_frame();
        run_beats(50, 1'b0, BEATS, nb, nc);
        n_total++;
        if (nc <= BEATS) $display("FAIL bp_stalls: got %0d cycles, want more than %0d", nc, BEATS);
        else n_pass++;
        check_drain(1'b0, 1'b0);
    endtask

    task automatic test_abort();
        int nb, nc;
        int n_done = 0;
        start_frame();
        run_beats(100, 1'b0, 100, nb, nc);
        abort = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        bus.out_ready = 1'b0;
        n_total++;
        if ({bus.out_valid, busy, done, obs_beat()} !== 22'd0 || state !== IDLE)
            $display("FAIL abort_outputs: got valid=%b busy=%b done=%b payload=%h state=%0d, want all 0",
                     bus.out_valid, busy, done, obs_beat(), state);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) n_done++;
            @(negedge clk);
        end
        n_total++;
        if (n_done != 0) $display("FAIL abort_no_done: got %0d done pulses, want 0", n_done);
        else n_pass++;
        start_frame();
        run_beats(100, 1'b0, BEATS, nb, nc);
        check_drain(1'b0, 1'b0);
    endtask

    task automatic test_restart_pokes();
        int nb, nc;
        start_frame();
        run_beats(100, 1'b1, BEATS, nb, nc);
        check_drain(1'b1, 1'b0);
    endtask

    task automatic test_rst_drain();
        int nb, nc;
        start_frame();
        run_beats(100, 1'b0, BEATS, nb, nc);
        check_drain(1'b0, 1'b1);
        start_frame();
        run_beats(70, 1'b0, BEATS, nb, nc);
        check_drain(1'b0, 1'b0);
    endtask

    task automatic test_pipe_lat0();
        int k = 0;
        int cyc = 0;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        while (k < BEATS && cyc < 1000) begin
            if (k == BEATS - 1) begin
                n_total++;
                if ({bus0.row, bus0.col, bus0.tile, bus0.first_in_tile, bus0.last_in_tile, bus0.last_frame} !== exp_beat(k))
                    $display("FAIL lat0_last_beat: got %h, want %h",
                             {bus0.row, bus0.col, bus0.tile, bus0.first_in_tile, bus0.last_in_tile, bus0.last_frame}, exp_beat(k));
                else n_pass++;
            end
            if (bus0.out_valid === 1'b1) k++;
            cyc++;
            @(negedge clk);
        end
        n_total++;
        if (k != BEATS || cyc != BEATS) $display("FAIL lat0_beats: got %0d beats in %0d cycles, want %0d in %0d", k, cyc, BEATS, BEATS);
        else n_pass++;
        n_total++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || bus0.out_valid !== 1'b0)
            $display("FAIL lat0_done: got done=%b busy=%b valid=%b, want 1 0 0", done0, busy0, bus0.out_valid);
        else n_pass++;
        bus0.out_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (done0 !== 1'b0 || state0 !== IDLE)
            $display("FAIL lat0_pulse: got done=%b state=%0d, want 0 IDLE", done0, state0);
        else n_pass++;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        bus0.out_ready = 1'b0;
        test_reset();
        test_start_abort();
        test_basic();
        test_backpressure();
        test_abort();
        test_restart_pokes();
        test_rst_drain();
        test_pipe_lat0();
        n_total++;
        if (bd_viol != 0 || bd_viol0 != 0)
            $display("FAIL busy_with_done: got %0d/%0d overlaps, want 0", bd_viol, bd_viol0);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv_scan_ctrl.md
Name: conv_scan_ctrl

Overview:
Frame-level scan controller for the convolution datapath. On start it walks every tile of the input feature map in a fixed order and emits one (row, col) window coordinate per accepted beat over a valid/ready handshake. After the last beat it waits out the downstream MAC pipeline latency, then pulses done. It replaces free-running coordinate counters with a sequenced, stallable and abortable source.

Parameters:
COORD_W, 7, width of row/col outputs
TILE_ROWS, 10, rows per tile (local row 0..TILE_ROWS-1)
TILE_COLS, 8, cols per tile
ROW_STEP, 8, row origin step between vertically adjacent tiles (overlap = TILE_ROWS-ROW_STEP)
COL_STEP, 8, col origin step between horizontally adjacent tiles
N_TR, 2, tiles per column of tiles (vertical)
N_TC, 2, tiles per row of tiles (horizontal)
PIPE_LAT, 4, drain cycles after final beat before done (0 allowed)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin frame scan; sampled only in IDLE
abort  in  1  synchronous cancel, any state
out_valid  out  1  coordinate valid
out_ready  in  1  downstream accepts coordinate
row  out  COORD_W  absolute row = tr*ROW_STEP + r
col  out  COORD_W  absolute col = tc*COL_STEP + c
tile  out  clog2(N_TR*N_TC)  tile index = tc*N_TR + tr
first_in_tile  out  1  r==0 && c==0
last_in_tile  out  1  r==TILE_ROWS-1 && c==TILE_COLS-1
last_frame  out  1  last_in_tile on final tile
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle completion pulse

Behaviour:
- Single clock domain on clk. rst is synchronous and active-high; it has priority over everything else.
- Reset values: state=IDLE; out_valid, busy, done, first_in_tile, last_in_tile and last_frame all 0; row, col and tile all 0.
- All outputs are registered.
- FSM states: IDLE, RUN, DRAIN.
- IDLE, start=1 (abort=0): load r=c=tr=tc=0 and enter RUN. out_valid=1 and busy=1 from the next cycle, with first beat row=0, col=0, tile=0, first_in_tile=1.
- RUN: out_valid stays 1.
- A beat fires when out_valid && out_ready. While out_ready=0, row, col, tile and all flags hold stable.
- Advance order on each fire:
  - r increments first.
  - At r wrap, c increments.
  - At c wrap, tr increments.
  - At tr wrap, tc increments.
  - Default sweep: tile0 (0,0), tile1 (8,0), tile2 (0,8), tile3 (8,8).
- Total beats = N_TR*N_TC*TILE_ROWS*TILE_COLS = 320 by default.
- Fire with last_frame=1:
  - out_valid falls on that edge.
  - If PIPE_LAT>0, enter DRAIN and load drain counter with PIPE_LAT.
  - If PIPE_LAT=0, go directly to IDLE with done=1.
- DRAIN: decrement the counter each cycle. When it would reach 0, go to IDLE with done=1 and busy=0. done is therefore high in the cycle beginning PIPE_LAT edges after the final-accept edge.
- done is high for exactly one cycle. busy=0 while done=1.
- start outside IDLE is ignored: no restart and no effect on coordinates.
- abort=1 in any state: next cycle state=IDLE, out_valid=0, busy=0, done=0. Coordinates reset to 0; no done is ever produced for an aborted frame.
- Priority: abort over start. If start and abort are both high in IDLE, stay in IDLE.
- Width rule: the elaboration-time check requires (N_TR-1)*ROW_STEP+TILE_ROWS-1 < 2**COORD_W, and likewise for columns. Origins are computed incrementally (add STEP at tile advance), so no multiplier is used.
- rst mid-frame: same as abort, with all outputs at reset values next cycle.

Decomposition:
- Shared package conv_pkg:
  - scan_state_t enum {IDLE, RUN, DRAIN}
  - default geometry constants (TILE_ROWS, TILE_COLS, ROW_STEP, COL_STEP, N_TR, N_TC)
  - a function computing the tile index width
- One natural sub-module: scan_coord_gen. It holds the r/c/tr/tc counters, origin accumulators and flag logic, with an advance and clear interface.
- The FSM, drain counter and handshake stay in conv_scan_ctrl.

Test Plan:
- Defaults, out_ready=1, start pulsed at edge T:
  - 320 beats on consecutive cycles.
  - Beats 0..9 are rows 0..9 at col 0; beat 10 is (0,1).
  - Beat 80 is (8,0) with tile=1; beat 160 is (0,8) with tile=2; beat 319 is (17,15) with tile=3 and last_frame=1.
  - done is high in exactly one cycle, 4 edges after the final accept.
- Random out_ready backpressure (~50%):
  - Coordinate stream is identical to the first scenario.
  - Outputs are stable whenever valid && !ready.
  - Beat count is 320 and done arrives once.
- abort asserted at beat 100 (mid tile1):
  - Next cycle out_valid=0, busy=0, no done.
  - A fresh start restarts at (0,0) tile 0.
- start re-pulsed at beats 5 and 200, and during DRAIN:
  - No perturbation to the sequence.
  - Single done.
- PIPE_LAT=0:
  - done is high in the cycle immediately after the final-accept edge.
  - busy is never high simultaneously with done.
- rst asserted during DRAIN:
  - All outputs reset next cycle.
  - done never fires.
  - A following start yields a correct full frame.
